// File: rtl/catch_led_engine.sv
// Catch-the-LED game core: a single lit LED bounces across N_LEDS outputs and the player
// scores by matching sw to it and pressing the button. Tracks lives, speed level and game over.
module catch_led_engine #(
  parameter int unsigned N_LEDS     = 10,
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MAX_PERIOD = 4,
  parameter int unsigned MAX_LEVEL  = 3,
  parameter int unsigned LEVEL_UP   = 3,
  parameter int unsigned FLASH_CYC  = 2
) (
  input  logic               clk_1Hz,
  input  logic               reset,
  input  logic               button_i,
  input  logic [N_LEDS-1:0]  sw_i,
  output logic [N_LEDS-1:0]  led_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [2:0]         lives_o,
  output logic [1:0]         level_o,
  output logic               game_over_o
);

  localparam int unsigned CntW   = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
  localparam int unsigned HitW   = $clog2(LEVEL_UP + 1);
  localparam int unsigned FlashW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

  typedef enum logic [1:0] {StPlay, StMiss, StOver} state_e;

  state_e             state_q, state_d;
  logic [N_LEDS-1:0]  led_q, led_d;
  logic               dir_up_q, dir_up_d;
  logic [CntW-1:0]    step_cnt_q, step_cnt_d;
  logic [FlashW-1:0]  flash_cnt_q, flash_cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [1:0]         level_q, level_d;
  logic [HitW-1:0]    hits_q, hits_d;
  logic               game_over_q, game_over_d;
  logic               btn_s1_q, btn_s2_q, btn_prev_q;

  logic              press;
  logic              step_fire;
  logic [CntW-1:0]   last_cnt;
  logic [N_LEDS-1:0] led_step;

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      state_q     <= StPlay;
      led_q       <= N_LEDS'(1);
      dir_up_q    <= 1'b1;
      step_cnt_q  <= '0;
      flash_cnt_q <= '0;
      score_q     <= '0;
      lives_q     <= 3'(LIVES);
      level_q     <= '0;
      hits_q      <= '0;
      game_over_q <= 1'b0;
      btn_s1_q    <= 1'b1;
      btn_s2_q    <= 1'b1;
      btn_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      dir_up_q    <= dir_up_d;
      step_cnt_q  <= step_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      hits_q      <= hits_d;
      game_over_q <= game_over_d;
      btn_s1_q    <= button_i;
      btn_s2_q    <= btn_s1_q;
      btn_prev_q  <= btn_s2_q;
    end
  end

  // Step period shrinks by one per level but never below one cycle.
  always_comb begin
    last_cnt = '0;
    if (MAX_PERIOD > 32'(level_q) + 32'd1) begin
      last_cnt = CntW'(MAX_PERIOD - 32'(level_q) - 32'd1);
    end
  end

  assign press     = btn_prev_q & ~btn_s2_q;
  assign step_fire = (step_cnt_q >= last_cnt);
  assign led_step  = dir_up_q ? (led_q << 1) : (led_q >> 1);

  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    dir_up_d    = dir_up_q;
    step_cnt_d  = step_cnt_q;
    flash_cnt_d = flash_cnt_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    hits_d      = hits_q;
    game_over_d = game_over_q;

    unique case (state_q)
      StPlay: begin
        if (step_fire) begin
          step_cnt_d = '0;
          led_d      = led_step;
          if (dir_up_q && led_step[N_LEDS-1]) begin
            dir_up_d = 1'b0;
          end else if (!dir_up_q && led_step[0]) begin
            dir_up_d = 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end

        // The guess is judged against the LED shown before this edge's step.
        if (press) begin
          if (sw_i == led_q) begin
            if (score_q != '1) begin
              score_d = score_q + 1'b1;
            end
            if (hits_q == HitW'(LEVEL_UP - 1)) begin
              hits_d = '0;
              if (level_q < 2'(MAX_LEVEL)) begin
                level_d = level_q + 1'b1;
              end
            end else begin
              hits_d = hits_q + 1'b1;
            end
          end else begin
            led_d      = '1;
            step_cnt_d = '0;
            lives_d    = lives_q - 1'b1;
            if (lives_q == 3'd1) begin
              state_d     = StOver;
              game_over_d = 1'b1;
            end else begin
              state_d     = StMiss;
              flash_cnt_d = '0;
            end
          end
        end
      end

      StMiss: begin
        led_d      = '1;
        step_cnt_d = '0;
        if (flash_cnt_q == FlashW'(FLASH_CYC - 1)) begin
          state_d  = StPlay;
          led_d    = N_LEDS'(1);
          dir_up_d = 1'b1;
        end else begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
      end

      StOver: begin
        led_d = '1;
        if (press) begin
          state_d     = StPlay;
          led_d       = N_LEDS'(1);
          dir_up_d    = 1'b1;
          step_cnt_d  = '0;
          flash_cnt_d = '0;
          score_d     = '0;
          lives_d     = 3'(LIVES);
          level_d     = '0;
          hits_d      = '0;
          game_over_d = 1'b0;
        end
      end

      default: begin
        state_d = StPlay;
      end
    endcase
  end

  assign led_o       = led_q;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign level_o     = level_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_catch_led_engine.sv
// Bench for catch_led_engine: a behavioural game model is checked on every falling edge,
// and directed scenarios pin key values with literal expectations.
module tb_catch_led_engine;

  localparam int N  = 10;
  localparam int SW = 4;
  localparam int LV = 3;
  localparam int MP = 4;
  localparam int ML = 3;
  localparam int LU = 3;
  localparam int FC = 2;

  localparam int MPlay = 0;
  localparam int MMiss = 1;
  localparam int MOver = 2;

  logic          clk_1Hz = 1'b0;
  logic          reset;
  logic          button;
  logic [N-1:0]  sw;
  logic [N-1:0]  led_o;
  logic [SW-1:0] score_o;
  logic [2:0]    lives_o;
  logic [1:0]    level_o;
  logic          game_over_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  catch_led_engine #(
    .N_LEDS(N), .SCORE_W(SW), .LIVES(LV), .MAX_PERIOD(MP),
    .MAX_LEVEL(ML), .LEVEL_UP(LU), .FLASH_CYC(FC)
  ) u_dut (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .button_i    (button),
    .sw_i        (sw),
    .led_o       (led_o),
    .score_o     (score_o),
    .lives_o     (lives_o),
    .level_o     (level_o),
    .game_over_o (game_over_o)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Game model: position index + direction, plain integer counters.
  int       m_st, m_pos, m_cnt, m_score, m_lives, m_level, m_hits, m_flash_left;
  bit       m_up;
  bit [2:0] bh;  // bh[k] = button sampled k+1 edges ago

  function automatic logic [N-1:0] m_led();
    logic [N-1:0] one;
    one = 1;
    if (m_st == MPlay) return one << m_pos;
    return '1;
  endfunction

  task automatic m_new_game();
    m_st = MPlay; m_pos = 0; m_up = 1; m_cnt = 0; m_score = 0;
    m_lives = LV; m_level = 0; m_hits = 0; m_flash_left = 0;
  endtask

  task automatic m_step();
    bit press, missed;
    int per;
    press = bh[2] && !bh[1];
    bh = {bh[1:0], button};
    missed = 0;
    case (m_st)
      MPlay: begin
        per = (MP - m_level > 1) ? MP - m_level : 1;
        if (press) begin
          if (sw == m_led()) begin
            if (m_score < 2 ** SW - 1) m_score++;
            m_hits++;
            if (m_hits == LU) begin
              m_hits = 0;
              if (m_level < ML) m_level++;
            end
          end else begin
            missed = 1;
            m_lives--;
            m_cnt = 0;
            if (m_lives == 0) m_st = MOver;
            else begin
              m_st = MMiss;
              m_flash_left = FC - 1;
            end
          end
        end
        if (!missed) begin
          if (m_cnt + 1 >= per) begin
            m_cnt = 0;
            if (m_up) begin
              m_pos++;
              if (m_pos == N - 1) m_up = 0;
            end else begin
              m_pos--;
              if (m_pos == 0) m_up = 1;
            end
          end else m_cnt++;
        end
      end
      MMiss: begin
        if (m_flash_left == 0) begin
          m_st = MPlay; m_pos = 0; m_up = 1; m_cnt = 0;
        end else m_flash_left--;
      end
      default: begin
        if (press) m_new_game();
      end
    endcase
  endtask

  always @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      m_new_game();
      bh = 3'b111;
    end else begin
      m_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_1Hz) begin
    if (chk_en) begin
      chk("model_led", 32'(led_o), 32'(m_led()));
      chk("model_score", 32'(score_o), m_score);
      chk("model_lives", 32'(lives_o), m_lives);
      chk("model_level", 32'(level_o), m_level);
      chk("model_game_over", 32'(game_over_o), (m_st == MOver) ? 1 : 0);
    end
  end

  // One button press; sw is set to the current LED (hit) or zero just before the edge that
  // acts on the press. Returns on the falling edge after that edge.
  task automatic press_at(input bit hit);
    @(negedge clk_1Hz);
    button = 1'b0;
    @(negedge clk_1Hz);
    @(negedge clk_1Hz);
    sw = hit ? m_led() : '0;
    @(negedge clk_1Hz);
    button = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] prev;
    int gap;
    int gaps[$];
    reset  = 1'b1;
    button = 1'b1;
    sw     = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_led", 32'(led_o), 32'h001);
    chk("rst_score", 32'(score_o), 0);
    chk("rst_lives", 32'(lives_o), 3);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_game_over", 32'(game_over_o), 0);
    chk_en = 1'b1;
    @(negedge clk_1Hz);
    @(negedge clk_1Hz);
    reset = 1'b1;

    // Free-running bounce
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk_1Hz);
      if (c == 3)  chk("bounce_c3", 32'(led_o), 32'h001);
      if (c == 4)  chk("bounce_c4", 32'(led_o), 32'h002);
      if (c == 35) chk("bounce_c35", 32'(led_o), 32'h100);
      if (c == 36) chk("bounce_c36", 32'(led_o), 32'h200);
      if (c == 39) chk("bounce_c39", 32'(led_o), 32'h200);
      if (c == 40) chk("bounce_c40", 32'(led_o), 32'h100);
      if (c == 72) chk("bounce_c72", 32'(led_o), 32'h001);
      if (c == 75) chk("bounce_c75", 32'(led_o), 32'h001);
      if (c == 76) chk("bounce_c76", 32'(led_o), 32'h002);
    end

    // Three hits -> level 1, period 3
    press_at(1'b1);
    chk("hit1_score", 32'(score_o), 1);
    press_at(1'b1);
    chk("hit2_score", 32'(score_o), 2);
    press_at(1'b1);
    chk("hit3_score", 32'(score_o), 3);
    chk("hit3_level", 32'(level_o), 1);
    prev = led_o;
    gap = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_1Hz);
      gap++;
      if (led_o !== prev) begin
        gaps.push_back(gap);
        gap = 0;
        prev = led_o;
      end
    end
    chk("lvl1_step_count", (gaps.size() >= 3) ? 1 : 0, 1);
    if (gaps.size() >= 3) begin
      chk("lvl1_period_a", gaps[1], 3);
      chk("lvl1_period_b", gaps[2], 3);
    end

    // Non-fatal miss with flash
    press_at(1'b0);
    chk("miss_lives", 32'(lives_o), 2);
    chk("miss_flash0", 32'(led_o), 32'h3FF);
    chk("miss_score", 32'(score_o), 3);
    @(negedge clk_1Hz);
    chk("miss_flash1", 32'(led_o), 32'h3FF);
    @(negedge clk_1Hz);
    chk("miss_back", 32'(led_o), 32'h001);

    // Game over and restart
    press_at(1'b0);
    chk("miss2_lives", 32'(lives_o), 1);
    press_at(1'b0);
    chk("over_lives", 32'(lives_o), 0);
    chk("over_flag", 32'(game_over_o), 1);
    repeat (20) @(negedge clk_1Hz);
    chk("over_led_held", 32'(led_o), 32'h3FF);
    chk("over_score_frozen", 32'(score_o), 3);
    chk("over_flag_held", 32'(game_over_o), 1);
    press_at(1'b0);
    chk("restart_score", 32'(score_o), 0);
    chk("restart_lives", 32'(lives_o), 3);
    chk("restart_level", 32'(level_o), 0);
    chk("restart_led", 32'(led_o), 32'h001);
    chk("restart_flag", 32'(game_over_o), 0);

    // Press acting on a step edge: judged against the pre-step LED
    press_at(1'b1);
    chk("edge_hit_score", 32'(score_o), 1);
    chk("edge_hit_led", 32'(led_o), 32'h002);

    // Held button counts once
    @(negedge clk_1Hz);
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_1Hz);
      sw = m_led();
    end
    button = 1'b1;
    repeat (3) @(negedge clk_1Hz);
    chk("held_once_score", 32'(score_o), 2);

    // Saturation
    for (int i = 0; i < 16; i++) press_at(1'b1);
    chk("sat_score", 32'(score_o), 15);
    chk("sat_level", 32'(level_o), 3);

    // Reset during MISS
    press_at(1'b0);
    chk("pre_rst_flash", 32'(led_o), 32'h3FF);
    #1 reset = 1'b0;
    #1;
    chk("rst_miss_led", 32'(led_o), 32'h001);
    chk("rst_miss_score", 32'(score_o), 0);
    chk("rst_miss_lives", 32'(lives_o), 3);
    chk("rst_miss_level", 32'(level_o), 0);
    @(negedge clk_1Hz);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_1Hz);
      if (i < 4) chk("post_rst_hold", 32'(led_o), 32'h001);
      else       chk("post_rst_step", 32'(led_o), 32'h002);
    end

    // Reset during OVER
    press_at(1'b0);
    press_at(1'b0);
    press_at(1'b0);
    chk("over2_flag", 32'(game_over_o), 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_over_flag", 32'(game_over_o), 0);
    chk("rst_over_led", 32'(led_o), 32'h001);
    chk("rst_over_lives", 32'(lives_o), 3);
    @(negedge clk_1Hz);
    reset = 1'b1;
    repeat (10) @(negedge clk_1Hz);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
